// File: rtl/coeff_replay_fifo.sv
// Coefficient FIFO with a replay mark: words read since the last commit stay
// resident and can be re-read by rewinding the read pointer to the mark.
module coeff_replay_fifo #(
  parameter int                  DATA_W   = 32,
  parameter int                  ADDR_W   = 4,
  parameter logic [DATA_W-1:0]   MARKER   = 32'h7F90_0000,
  parameter int                  AFULL_TH = (1 << ADDR_W) - 2
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              rd_en_i,
  input  logic              redo_i,
  input  logic              commit_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              start_o,
  output logic              full_o,
  output logic              afull_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   count_o,
  output logic              ovf_o,
  output logic              udf_o
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam int              PW      = ADDR_W + 1;
  localparam logic [PW-1:0]   DEPTH_V = PW'(DEPTH);
  localparam logic [PW-1:0]   AFULL_V = PW'(AFULL_TH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr, r_rd_ptr, r_mark;
  logic [DATA_W-1:0] r_data;
  logic              r_valid, r_start, r_ovf, r_udf;

  logic [PW-1:0] w_occ, w_rd_next, w_mark_next;
  logic          w_full, w_empty, w_is_marker;
  logic          w_wr_acc, w_rd_acc, w_ovf_ev, w_udf_ev;

  // Occupancy is measured from the mark, so consumed-but-uncommitted words
  // still hold their slots; the wrap bit distinguishes full from empty.
  always_comb begin
    w_occ       = r_wr_ptr - r_mark;
    w_full      = (w_occ == DEPTH_V);
    w_empty     = (r_wr_ptr == r_rd_ptr);
    w_is_marker = (data_i == MARKER);

    w_wr_acc = wr_en_i && !w_full && !w_is_marker;
    w_ovf_ev = wr_en_i &&  w_full && !w_is_marker;
    w_rd_acc = rd_en_i && !w_empty && !redo_i;
    w_udf_ev = rd_en_i &&  w_empty && !redo_i;

    // Replay wins over both read and commit in the same cycle.
    if (redo_i) begin
      w_rd_next   = r_mark;
      w_mark_next = r_mark;
    end else begin
      w_rd_next   = r_rd_ptr + PW'(w_rd_acc);
      w_mark_next = commit_i ? w_rd_next : r_mark;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_mark   <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_start  <= 1'b0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PW'(1);
      r_rd_ptr <= w_rd_next;
      r_mark   <= w_mark_next;
      if (w_rd_acc) r_data <= r_mem[r_rd_ptr[ADDR_W-1:0]];
      r_valid  <= w_rd_acc;
      r_start  <= wr_en_i && w_is_marker;
      if (w_ovf_ev) r_ovf <= 1'b1;
      if (w_udf_ev) r_udf <= 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers alone define which words are
  // live, and a resettable array would cost a flop-based memory.
  always_ff @(posedge clk_i) begin
    if (w_wr_acc) r_mem[r_wr_ptr[ADDR_W-1:0]] <= data_i;
  end

  assign data_o  = r_data;
  assign valid_o = r_valid;
  assign start_o = r_start;
  assign full_o  = w_full;
  assign afull_o = (w_occ >= AFULL_V);
  assign empty_o = w_empty;
  assign count_o = r_wr_ptr - r_rd_ptr;
  assign ovf_o   = r_ovf;
  assign udf_o   = r_udf;

endmodule

// File: tb/tb_coeff_replay_fifo.sv
// Directed vector bench for coeff_replay_fifo at DEPTH=4, AFULL_TH=2:
// fill/overflow, replay, commit, marker, underflow and async reset.
module tb_coeff_replay_fifo;

  localparam int          DATA_W = 32;
  localparam int          ADDR_W = 2;
  localparam logic [31:0] MARK   = 32'h7F90_0000;

  logic              clk_i = 1'b0;
  logic              rstn_i;
  logic              wr_en_i, rd_en_i, redo_i, commit_i;
  logic [DATA_W-1:0] data_i;
  logic [DATA_W-1:0] data_o;
  logic              valid_o, start_o, full_o, afull_o, empty_o, ovf_o, udf_o;
  logic [ADDR_W:0]   count_o;

  int checks = 0;
  int errors = 0;

  coeff_replay_fifo #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MARKER(MARK), .AFULL_TH(2)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .wr_en_i(wr_en_i), .data_i(data_i),
    .rd_en_i(rd_en_i), .redo_i(redo_i), .commit_i(commit_i),
    .data_o(data_o), .valid_o(valid_o), .start_o(start_o),
    .full_o(full_o), .afull_o(afull_o), .empty_o(empty_o),
    .count_o(count_o), .ovf_o(ovf_o), .udf_o(udf_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        wr;
    logic [31:0] din;
    logic        rd, redo, commit;
    logic [31:0] e_data;
    logic        e_valid, e_start, e_full, e_afull, e_empty;
    logic [2:0]  e_count;
    logic        e_ovf, e_udf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input vec_t v);
    check({tag, " data_o"},  data_o,         v.e_data);
    check({tag, " valid_o"}, 32'(valid_o),   32'(v.e_valid));
    check({tag, " start_o"}, 32'(start_o),   32'(v.e_start));
    check({tag, " full_o"},  32'(full_o),    32'(v.e_full));
    check({tag, " afull_o"}, 32'(afull_o),   32'(v.e_afull));
    check({tag, " empty_o"}, 32'(empty_o),   32'(v.e_empty));
    check({tag, " count_o"}, 32'(count_o),   32'(v.e_count));
    check({tag, " ovf_o"},   32'(ovf_o),     32'(v.e_ovf));
    check({tag, " udf_o"},   32'(udf_o),     32'(v.e_udf));
  endtask

  // Inputs first, then expected outputs one cycle after the edge.
  function automatic vec_t mk(
    input logic wr, input logic [31:0] din, input logic rd, input logic redo,
    input logic commit, input logic [31:0] e_data, input logic e_valid,
    input logic e_start, input logic e_full, input logic e_afull,
    input logic e_empty, input logic [2:0] e_count, input logic e_ovf,
    input logic e_udf);
    vec_t v;
    v.wr = wr; v.din = din; v.rd = rd; v.redo = redo; v.commit = commit;
    v.e_data = e_data; v.e_valid = e_valid; v.e_start = e_start;
    v.e_full = e_full; v.e_afull = e_afull; v.e_empty = e_empty;
    v.e_count = e_count; v.e_ovf = e_ovf; v.e_udf = e_udf;
    return v;
  endfunction

  task automatic idle_inputs();
    wr_en_i = 0; rd_en_i = 0; redo_i = 0; commit_i = 0; data_i = '0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    localparam logic [31:0] A = 32'hA1, B = 32'hB2, C = 32'hC3, D = 32'hD4;
    localparam logic [31:0] E = 32'hE5, X = 32'h1234_5678, Y = 32'h0BAD_F00D;
    localparam logic [31:0] Z = 32'h2222, W1 = 32'h3333, W2 = 32'h4444;
    vec_t rst_v;

    //        wr din  rd rdo cmt  data vld st  ful afl emp cnt ovf udf
    vecs.push_back(mk(1, A,   0, 0, 0,   0,  0,  0,  0,  0,  0,  1,  0,  0));
    vecs.push_back(mk(1, B,   0, 0, 0,   0,  0,  0,  0,  1,  0,  2,  0,  0));
    vecs.push_back(mk(1, C,   0, 0, 0,   0,  0,  0,  0,  1,  0,  3,  0,  0));
    vecs.push_back(mk(1, D,   0, 0, 0,   0,  0,  0,  1,  1,  0,  4,  0,  0));
    vecs.push_back(mk(1, E,   0, 0, 0,   0,  0,  0,  1,  1,  0,  4,  1,  0));
    vecs.push_back(mk(1, MARK,0, 0, 0,   0,  0,  1,  1,  1,  0,  4,  1,  0));
    vecs.push_back(mk(0, 0,   1, 0, 0,   A,  1,  0,  1,  1,  0,  3,  1,  0));
    vecs.push_back(mk(0, 0,   1, 0, 0,   B,  1,  0,  1,  1,  0,  2,  1,  0));
    vecs.push_back(mk(0, 0,   1, 0, 0,   C,  1,  0,  1,  1,  0,  1,  1,  0));
    vecs.push_back(mk(0, 0,   1, 0, 0,   D,  1,  0,  1,  1,  1,  0,  1,  0));
    vecs.push_back(mk(0, 0,   0, 1, 0,   D,  0,  0,  1,  1,  0,  4,  1,  0));
    vecs.push_back(mk(0, 0,   1, 0, 0,   A,  1,  0,  1,  1,  0,  3,  1,  0));
    vecs.push_back(mk(0, 0,   1, 0, 0,   B,  1,  0,  1,  1,  0,  2,  1,  0));
    vecs.push_back(mk(0, 0,   0, 0, 1,   B,  0,  0,  0,  1,  0,  2,  1,  0));
    vecs.push_back(mk(1, MARK,0, 0, 0,   B,  0,  1,  0,  1,  0,  2,  1,  0));
    vecs.push_back(mk(0, 0,   0, 0, 0,   B,  0,  0,  0,  1,  0,  2,  1,  0));
    vecs.push_back(mk(0, 0,   1, 0, 0,   C,  1,  0,  0,  1,  0,  1,  1,  0));
    vecs.push_back(mk(0, 0,   1, 0, 0,   D,  1,  0,  0,  1,  1,  0,  1,  0));
    vecs.push_back(mk(1, X,   1, 0, 0,   D,  0,  0,  0,  1,  0,  1,  1,  1));
    vecs.push_back(mk(0, 0,   1, 0, 0,   X,  1,  0,  0,  1,  1,  0,  1,  1));
    vecs.push_back(mk(1, Y,   0, 0, 0,   X,  0,  0,  1,  1,  0,  1,  1,  1));
    vecs.push_back(mk(1, Z,   0, 0, 1,   X,  0,  0,  0,  0,  0,  1,  1,  1));
    vecs.push_back(mk(0, 0,   1, 0, 0,   Y,  1,  0,  0,  0,  1,  0,  1,  1));
    vecs.push_back(mk(0, 0,   1, 1, 1,   Y,  0,  0,  0,  0,  0,  1,  1,  1));
    vecs.push_back(mk(0, 0,   1, 0, 0,   Y,  1,  0,  0,  0,  1,  0,  1,  1));
    vecs.push_back(mk(1, W1,  0, 0, 0,   Y,  0,  0,  0,  1,  0,  1,  1,  1));
    vecs.push_back(mk(1, W2,  1, 0, 0,  W1,  1,  0,  0,  1,  0,  1,  1,  1));
    vecs.push_back(mk(0, 0,   1, 0, 1,  W2,  1,  0,  0,  0,  1,  0,  1,  1));

    rst_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

    idle_inputs();
    rstn_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_all("reset", rst_v);
    rstn_i = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      wr_en_i  = vecs[i].wr;
      data_i   = vecs[i].din;
      rd_en_i  = vecs[i].rd;
      redo_i   = vecs[i].redo;
      commit_i = vecs[i].commit;
      @(posedge clk_i);
      #1;
      check_all($sformatf("v%0d", i), vecs[i]);
    end

    // Fill three words, then pull reset between edges.
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      wr_en_i = 1;
      data_i  = 32'h100 + 32'(i);
      @(posedge clk_i);
      #1;
    end
    idle_inputs();
    check("pre-reset count_o", 32'(count_o), 32'd3);
    check("pre-reset afull_o", 32'(afull_o), 32'd1);
    #2;
    rstn_i = 1'b0;
    #1;
    check_all("async-reset", rst_v);
    #10;
    rstn_i = 1'b1;
    @(posedge clk_i);
    #1;
    check_all("post-reset", rst_v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
